// File: rtl/unidade_busca.sv
// Instruction fetch stage: switch-loaded program memory, PC and a
// valid/ready instruction port with free-run, single-step, jump and HALT.
module unidade_busca #(
  parameter int          ADDR_W  = 4,
  parameter int          DEPTH   = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              run,
  input  logic              step,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_t;

  state_t            state;
  logic              step_mode;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        mem [DEPTH];

  assign pc_out = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      step_mode   <= 1'b0;
      pc          <= '0;
      instr_out   <= 8'h00;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_en)
            mem[load_addr] <= load_data;
          if (run) begin
            step_mode <= 1'b0;
            state     <= FETCH;
          end else if (step) begin
            step_mode <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          instr_out   <= mem[pc];
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            // HALT keeps the PC on the halt instruction
            if (instr_out[7:4] == HALT_OP) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc    <= jump_en ? jump_addr : pc + ADDR_W'(1);
              state <= step_mode ? IDLE : FETCH;
            end
          end
        end
        HALT: begin
          if (run) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
